alu_seq_ctrl: RTL and testbench

Byte-serial command sequencer that drives the team's combinational 8-bit ALU from a narrow 8-bit pin interface. It accepts three bytes per transaction over a valid/ready input stream: operand A, operand B, then a command byte. It holds the ALU inputs stable, captures the result and the flags, and returns them over a valid/ready output stream as a result byte followed by a flags byte. It is the initiator/consumer side of the ALU interface and sits between the top-level I/O pins and the ALU instance.

---
 rtl/alu_seq_ctrl_if.sv | 22 ++
 rtl/alu_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Byte-stream bundle between the pins and the ALU sequencer: an inbound
// valid/ready byte stream and an outbound valid/ready byte stream.
interface alu_seq_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // Pin side: sends operand/command bytes, receives result/flags bytes.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Sequencer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Byte-serial sequencer for a combinational 8-bit ALU: loads A, B and a
// command byte, holds the ALU inputs for EXEC_CYCLES, captures result and
// flags, then returns the result byte and (optionally) a flags byte.
module alu_seq_ctrl #(
  parameter int unsigned EXEC_CYCLES  = 1,
  parameter bit          FLAG_BYTE_EN = 1'b1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_ctrl_if.slave    bus,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_sh_sel,
  input  logic [7:0]       alu_y,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    StLoadA, StLoadB, StLoadCmd, StExec, StSendY, StSendF
  } state_e;

  state_e        state_q, state_d;
  logic [EW-1:0] exec_cnt;
  logic [7:0]    res_y;
  logic [7:0]    res_f;
  logic          in_ready;
  logic          out_valid;
  logic          in_fire;
  logic          capture;
  logic          txn_done;
  logic [3:0]    cmd_unused;

  // Command bits [7:4] carry no meaning.
  assign cmd_unused = bus.in_data[7:4];

  assign in_fire       = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  // Result/flags registers only change in EXEC, so out_data holds under backpressure.
  assign bus.out_data  = (state_q == StSendF) ? res_f : res_y;
  assign busy          = (state_q != StLoadA);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoadA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    txn_done  = 1'b0;
    unique case (state_q)
      StLoadA: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = StLoadB;
      end
      StLoadB: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = StLoadCmd;
      end
      StLoadCmd: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = StExec;
      end
      StExec: begin
        if (exec_cnt == EXEC_LAST) begin
          capture = 1'b1;
          state_d = StSendY;
        end
      end
      StSendY: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (FLAG_BYTE_EN) begin
            state_d = StSendF;
          end else begin
            txn_done = 1'b1;
            state_d  = StLoadA;
          end
        end
      end
      StSendF: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          txn_done = 1'b1;
          state_d  = StLoadA;
        end
      end
      default: state_d = StLoadA;
    endcase
  end

  // Operand/command capture, exec timing, result capture and transaction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_op     <= 3'd0;
      alu_sh_sel <= 1'b0;
      exec_cnt   <= '0;
      res_y      <= 8'h00;
      res_f      <= 8'h00;
      txn_count  <= '0;
    end else begin
      if (in_fire && state_q == StLoadA) alu_a <= bus.in_data;
      if (in_fire && state_q == StLoadB) alu_b <= bus.in_data;
      if (in_fire && state_q == StLoadCmd) begin
        alu_op     <= bus.in_data[2:0];
        alu_sh_sel <= bus.in_data[3];
        exec_cnt   <= '0;
      end else if (state_q == StExec) begin
        exec_cnt <= exec_cnt + EW'(1);
      end
      if (capture) begin
        res_y <= alu_y;
        res_f <= {4'b0000, alu_v, alu_n, alu_z, alu_c};
      end
      if (txn_done) txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: two instances (flags on / EXEC_CYCLES=1, and
// flags off / EXEC_CYCLES=3), each wired to a behavioural 8-bit ALU, with a
// transaction-level model checked every cycle plus literal expectations.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_ctrl_if b0 ();
  alu_seq_ctrl_if b1 ();

  logic [1:0][7:0] drv_data;
  logic [1:0]      drv_valid;
  logic [1:0]      drv_oready;
  logic [1:0][7:0] s_a, s_b, s_y, s_od, s_cnt;
  logic [1:0][2:0] s_op;
  logic [1:0]      s_sel, s_c, s_z, s_n, s_v, s_ir, s_ov, s_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // ALU: ops 0 add, 1 or, 2 xor, 3 asr, 4 sub, 5 shl, 6 and, 7 lsr.
  // Shifts use A when sel=1, else B. Returns {v,n,z,c,y}.
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic sel);
    logic [8:0] w;
    logic [7:0] s, y;
    logic c, v;
    s = sel ? a : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b};
        y = w[7:0];
        c = w[8];
        v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      3'd1: y = a | b;
      3'd2: y = a ^ b;
      3'd3: begin y = {s[7], s[7:1]}; c = s[0]; end
      3'd4: begin
        w = {1'b0, a} - {1'b0, b};
        y = w[7:0];
        c = ~w[8];
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      3'd5: begin y = {s[6:0], 1'b0}; c = s[7]; end
      3'd6: y = a & b;
      default: begin y = {1'b0, s[7:1]}; c = s[0]; end
    endcase
    return {v, y[7], (y == 8'h00), c, y};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_alu
    assign {s_v[k], s_n[k], s_z[k], s_c[k], s_y[k]} = alu_f(s_a[k], s_b[k], s_op[k], s_sel[k]);
  end

  assign b0.in_data   = drv_data[0];
  assign b0.in_valid  = drv_valid[0];
  assign b0.out_ready = drv_oready[0];
  assign b1.in_data   = drv_data[1];
  assign b1.in_valid  = drv_valid[1];
  assign b1.out_ready = drv_oready[1];
  assign s_ir[0] = b0.in_ready;
  assign s_ov[0] = b0.out_valid;
  assign s_od[0] = b0.out_data;
  assign s_ir[1] = b1.in_ready;
  assign s_ov[1] = b1.out_valid;
  assign s_od[1] = b1.out_data;

  alu_seq_ctrl #(.EXEC_CYCLES(1), .FLAG_BYTE_EN(1'b1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0),
    .alu_a(s_a[0]), .alu_b(s_b[0]), .alu_op(s_op[0]), .alu_sh_sel(s_sel[0]),
    .alu_y(s_y[0]), .alu_c(s_c[0]), .alu_z(s_z[0]), .alu_n(s_n[0]), .alu_v(s_v[0]),
    .busy(s_busy[0]), .txn_count(s_cnt[0])
  );

  alu_seq_ctrl #(.EXEC_CYCLES(3), .FLAG_BYTE_EN(1'b0), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1),
    .alu_a(s_a[1]), .alu_b(s_b[1]), .alu_op(s_op[1]), .alu_sh_sel(s_sel[1]),
    .alu_y(s_y[1]), .alu_c(s_c[1]), .alu_z(s_z[1]), .alu_n(s_n[1]), .alu_v(s_v[1]),
    .busy(s_busy[1]), .txn_count(s_cnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: loaded operands, pending output bytes, exec wait, count.
  logic [1:0][7:0] m_a, m_b, m_cnt, e_res, e_flg;
  logic [1:0][2:0] m_op;
  logic [1:0]      m_sel;
  int m_idx [2];
  int m_wait [2];
  int e_n [2];
  int e_pos [2];
  logic [7:0] rx0 [$];
  logic [7:0] rx1 [$];

  // Per-cycle compare against the transaction model; fires take effect at the next posedge.
  always @(negedge clk) begin : mon
    logic pend, exp_ov;
    logic [7:0] cur, d;
    logic [11:0] r;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_a[k] = 8'h00; m_b[k] = 8'h00; m_op[k] = 3'd0; m_sel[k] = 1'b0; m_cnt[k] = 8'h00;
        e_res[k] = 8'h00; e_flg[k] = 8'h00;
        m_idx[k] = 0; m_wait[k] = 0; e_n[k] = 0; e_pos[k] = 0;
      end else begin
        pend   = (e_n[k] != 0);
        exp_ov = pend && (m_wait[k] == 0);
        cur    = (e_pos[k] == 0) ? e_res[k] : e_flg[k];
        chk($sformatf("u%0d.in_ready", k), s_ir[k], !pend);
        chk($sformatf("u%0d.out_valid", k), s_ov[k], exp_ov);
        chk($sformatf("u%0d.busy", k), s_busy[k], pend || (m_idx[k] != 0));
        chk($sformatf("u%0d.alu_a", k), s_a[k], m_a[k]);
        chk($sformatf("u%0d.alu_b", k), s_b[k], m_b[k]);
        chk($sformatf("u%0d.alu_op", k), s_op[k], m_op[k]);
        chk($sformatf("u%0d.alu_sh_sel", k), s_sel[k], m_sel[k]);
        chk($sformatf("u%0d.txn_count", k), s_cnt[k], m_cnt[k]);
        if (exp_ov) chk($sformatf("u%0d.out_data", k), s_od[k], cur);
        if (pend && m_wait[k] != 0) m_wait[k]--;
        if (exp_ov && drv_oready[k]) begin
          if (k == 0) rx0.push_back(s_od[k]);
          else rx1.push_back(s_od[k]);
          e_n[k]--;
          e_pos[k]++;
          if (e_n[k] == 0) m_cnt[k] = m_cnt[k] + 8'd1;
        end
        if (!pend && drv_valid[k]) begin
          d = drv_data[k];
          case (m_idx[k])
            0: m_a[k] = d;
            1: m_b[k] = d;
            default: begin
              m_op[k]   = d[2:0];
              m_sel[k]  = d[3];
              r         = alu_f(m_a[k], m_b[k], d[2:0], d[3]);
              e_res[k]  = r[7:0];
              e_flg[k]  = {4'b0000, r[11:8]};
              e_n[k]    = (k == 0) ? 2 : 1;
              e_pos[k]  = 0;
              m_wait[k] = (k == 0) ? 1 : 3;
            end
          endcase
          m_idx[k] = (m_idx[k] + 1) % 3;
        end
      end
    end
  end

  task automatic push(input int k, input logic [7:0] d);
    int t;
    t = 0;
    drv_data[k]  = d;
    drv_valid[k] = 1'b1;
    @(negedge clk);
    while (!s_ir[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("push_accept", s_ir[k], 1'b1);
    @(posedge clk);
    #1;
    drv_valid[k] = 1'b0;
  endtask

  task automatic wait_rx(input int k, input int n);
    int t;
    t = 0;
    while (((k == 0) ? rx0.size() : rx1.size()) < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("rx_bytes", (k == 0) ? rx0.size() : rx1.size(), n);
  endtask

  task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic [7:0] cmd,
                      input logic [7:0] ey, input logic [7:0] ef);
    push(0, a);
    push(0, b);
    push(0, cmd);
    wait_rx(0, 2);
    chk("res_byte", rx0[0], ey);
    chk("flag_byte", rx0[1], ef);
    rx0.delete();
  endtask

  logic [7:0] wa, wb, wc;

  initial begin
    drv_data   = '0;
    drv_valid  = '0;
    drv_oready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", s_ir[0], 1'b1);
    chk("rst_out_valid", s_ov[0], 1'b0);
    chk("rst_busy", s_busy[0], 1'b0);
    chk("rst_out_data", s_od[0], 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run0(8'h7F, 8'h01, 8'h00, 8'h80, 8'h0C);
    chk("count_first", s_cnt[0], 8'd1);
    run0(8'h05, 8'h05, 8'h04, 8'h00, 8'h03);
    run0(8'h81, 8'h00, 8'h0D, 8'h02, 8'h01);
    run0(8'h00, 8'h80, 8'h03, 8'hC0, 8'h04);
    chk("count_four", s_cnt[0], 8'd4);

    // Backpressure in SEND_Y with junk on the inbound stream.
    drv_oready[0] = 1'b0;
    push(0, 8'h7F);
    push(0, 8'h01);
    push(0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      drv_data[0]  = 8'hEE;
      drv_valid[0] = i[0];
      @(negedge clk);
      if (i >= 1 && i <= 5) begin
        chk("bp_out_valid", s_ov[0], 1'b1);
        chk("bp_out_data", s_od[0], 8'h80);
        chk("bp_in_ready", s_ir[0], 1'b0);
      end
      @(posedge clk);
      #1;
    end
    chk("bp_alu_a", s_a[0], 8'h7F);
    drv_valid[0]  = 1'b0;
    drv_oready[0] = 1'b1;
    wait_rx(0, 2);
    chk("bp_res", rx0[0], 8'h80);
    chk("bp_flags", rx0[1], 8'h0C);
    rx0.delete();

    // Asynchronous reset after the B byte.
    push(0, 8'h11);
    push(0, 8'h22);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", s_ir[0], 1'b1);
    chk("arst_out_valid", s_ov[0], 1'b0);
    chk("arst_busy", s_busy[0], 1'b0);
    chk("arst_alu_a", s_a[0], 8'h00);
    chk("arst_alu_b", s_b[0], 8'h00);
    chk("arst_count", s_cnt[0], 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run0(8'h10, 8'h20, 8'h06, 8'h00, 8'h02);
    chk("count_after_rst", s_cnt[0], 8'd1);

    // 255 more transactions: 256 since reset, counter wraps to zero.
    for (int i = 0; i < 255; i++) begin
      wa = 8'(i);
      wb = 8'(i * 7 + 3);
      wc = 8'(i * 13);
      push(0, wa);
      push(0, wb);
      push(0, wc);
      wait_rx(0, 2);
      rx0.delete();
    end
    chk("count_wrap", s_cnt[0], 8'h00);

    // Result-only instance.
    push(1, 8'h7F); push(1, 8'h01); push(1, 8'h00);
    wait_rx(1, 1);
    push(1, 8'h05); push(1, 8'h05); push(1, 8'h04);
    wait_rx(1, 2);
    push(1, 8'h81); push(1, 8'h00); push(1, 8'h0D);
    wait_rx(1, 3);
    repeat (10) @(posedge clk);
    #1;
    chk("u1_byte_total", rx1.size(), 3);
    chk("u1_res0", rx1[0], 8'h80);
    chk("u1_res1", rx1[1], 8'h00);
    chk("u1_res2", rx1[2], 8'h02);
    chk("u1_count", s_cnt[1], 8'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
